// File: rtl/reg_bank_core.sv
// reg_bank_core: 32 x DATA_W architectural register file, one write port and
// two registered read ports (1-cycle read latency). Register 0 reads as zero.
//
// Each read port is built bit-sliced: for every data bit, a 32:1 mux selects
// that bit across all registers.
//
// Build option: define REGBANK_BYPASS_EN to forward a same-edge write to a
// read of the same (non-zero) address. Without it, a same-edge read returns
// the old contents.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   wr_en        write strobe
//   wr_addr      destination register index (writes to 0 are ignored)
//   wr_data      write value
//   rd_en_a/b    read request per port
//   rd_addr_a/b  source index per port
//   rd_data_a/b  registered read data (holds when no request)
//   rd_valid_a/b one-cycle pulse, one cycle after each request
//   wr_count     committed writes, saturating at 0xFFFF

// 32:1 single-bit mux primitive used for every read bit-slice.
module mux32 (
   input  logic [31:0] din,
   input  logic [4:0]  sel,
   output logic        dout
);
   assign dout = din[sel];
endmodule

module reg_bank_core #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [4:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en_a,
   input  logic [4:0]        rd_addr_a,
   input  logic              rd_en_b,
   input  logic [4:0]        rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic              rd_valid_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              rd_valid_b,
   output logic [15:0]       wr_count
);

   // Register 0 has no storage; its mux input is tied to zero.
   logic [DATA_W-1:0] regs [1:NUM_REGS-1];
   logic [DATA_W-1:0] sel_a;
   logic [DATA_W-1:0] sel_b;
   logic [DATA_W-1:0] next_a;
   logic [DATA_W-1:0] next_b;
   logic              wr_commit;

   assign wr_commit = wr_en && (wr_addr != 5'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 1; r < NUM_REGS; r++) regs[r] <= '0;
      end else if (wr_commit) begin
         for (int r = 1; r < NUM_REGS; r++) begin
            if (wr_addr == 5'(r)) regs[r] <= wr_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_count <= '0;
      end else if (wr_commit && (wr_count != 16'hFFFF)) begin
         wr_count <= wr_count + 16'd1;
      end
   end

   for (genvar b = 0; b < DATA_W; b++) begin : g_slice
      logic [NUM_REGS-1:0] col;
      for (genvar r = 0; r < NUM_REGS; r++) begin : g_col
         if (r == 0) begin : g_zero
            assign col[r] = 1'b0;
         end else begin : g_reg
            assign col[r] = regs[r][b];
         end
      end
      mux32 u_mux_a (.din(col), .sel(rd_addr_a), .dout(sel_a[b]));
      mux32 u_mux_b (.din(col), .sel(rd_addr_b), .dout(sel_b[b]));
   end

`ifdef REGBANK_BYPASS_EN
   // wr_commit already excludes address 0, so r0 keeps reading zero.
   assign next_a = (wr_commit && (rd_addr_a == wr_addr)) ? wr_data : sel_a;
   assign next_b = (wr_commit && (rd_addr_b == wr_addr)) ? wr_data : sel_b;
`else
   assign next_a = sel_a;
   assign next_b = sel_b;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_a  <= '0;
         rd_valid_a <= 1'b0;
         rd_data_b  <= '0;
         rd_valid_b <= 1'b0;
      end else begin
         rd_valid_a <= rd_en_a;
         rd_valid_b <= rd_en_b;
         if (rd_en_a) rd_data_a <= next_a;
         if (rd_en_b) rd_data_b <= next_b;
      end
   end

endmodule

// File: tb/tb_reg_bank_core.sv
// Testbench for reg_bank_core: directed vector table plus hand-written
// sequences for reset, full sweep and counter saturation. Expected read data
// goes into per-port queues when a read is driven and is popped when the
// valid pulse appears.
module tb_reg_bank_core;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        rd_en_a;
   logic [4:0]  rd_addr_a;
   logic        rd_en_b;
   logic [4:0]  rd_addr_b;
   logic [31:0] rd_data_a;
   logic        rd_valid_a;
   logic [31:0] rd_data_b;
   logic        rd_valid_b;
   logic [15:0] wr_count;

   reg_bank_core #(.DATA_W(32), .NUM_REGS(32)) dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
      .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
      .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b),
      .wr_count(wr_count)
   );

   always #5 clk = ~clk;

`ifdef REGBANK_BYPASS_EN
   localparam logic [31:0] HAZ = 32'h22222222;
`else
   localparam logic [31:0] HAZ = 32'h11111111;
`endif

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        rea;
      logic [4:0]  raa;
      logic        reb;
      logic [4:0]  rab;
      logic [31:0] ea;
      logic [31:0] eb;
      logic [15:0] ec;
   } vec_t;

   vec_t        tbl [11];
   logic [31:0] q_a [$];
   logic [31:0] q_b [$];
   logic [31:0] hold_a;
   logic [31:0] hold_b;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic rea, input logic [4:0] raa,
                               input logic reb, input logic [4:0] rab,
                               input logic [31:0] ea, input logic [31:0] eb,
                               input logic [15:0] ec);
      vec_t v;
      v.we = we; v.wa = wa; v.wd = wd; v.rea = rea; v.raa = raa;
      v.reb = reb; v.rab = rab; v.ea = ea; v.eb = eb; v.ec = ec;
      return v;
   endfunction

   task automatic idle_inputs();
      wr_en = 1'b0; wr_addr = 5'd0; wr_data = '0;
      rd_en_a = 1'b0; rd_addr_a = 5'd0; rd_en_b = 1'b0; rd_addr_b = 5'd0;
   endtask

   // Apply one vector for one clock edge, then check outputs 1 ns later.
   task automatic drive(input vec_t v, input string tag);
      logic [31:0] e;
      @(negedge clk);
      wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
      rd_en_a = v.rea; rd_addr_a = v.raa; rd_en_b = v.reb; rd_addr_b = v.rab;
      if (v.rea) q_a.push_back(v.ea);
      if (v.reb) q_b.push_back(v.eb);
      @(posedge clk);
      #1;
      chk({tag, " valid_a"}, {31'd0, rd_valid_a}, {31'd0, v.rea});
      chk({tag, " valid_b"}, {31'd0, rd_valid_b}, {31'd0, v.reb});
      if (rd_valid_a) begin
         if (q_a.size() == 0) chk({tag, " data_a unexpected"}, rd_data_a, hold_a);
         else begin
            e = q_a.pop_front();
            chk({tag, " data_a"}, rd_data_a, e);
            hold_a = e;
         end
      end else chk({tag, " hold_a"}, rd_data_a, hold_a);
      if (rd_valid_b) begin
         if (q_b.size() == 0) chk({tag, " data_b unexpected"}, rd_data_b, hold_b);
         else begin
            e = q_b.pop_front();
            chk({tag, " data_b"}, rd_data_b, e);
            hold_b = e;
         end
      end else chk({tag, " hold_b"}, rd_data_b, hold_b);
      chk({tag, " wr_count"}, {16'd0, wr_count}, {16'd0, v.ec});
   endtask

   initial begin
      logic [15:0] ec;
      logic [31:0] ea;
      logic [31:0] eb;

      // r0 write is ignored; both ports read r0 in the same cycle.
      tbl[0]  = mk(1, 5'd0, 32'h12345678, 0, 5'd0, 0, 5'd0, 0, 0, 16'd0);
      tbl[1]  = mk(0, 5'd0, 32'h0,        1, 5'd0, 1, 5'd0, 0, 0, 16'd0);
      // Same-edge read/write hazard on r7.
      tbl[2]  = mk(1, 5'd7, 32'h11111111, 0, 5'd0, 0, 5'd0, 0, 0, 16'd32);
      tbl[3]  = mk(1, 5'd7, 32'h22222222, 1, 5'd7, 0, 5'd0, HAZ, 0, 16'd33);
      tbl[4]  = mk(0, 5'd0, 32'h0,        1, 5'd7, 0, 5'd0, 32'h22222222, 0, 16'd33);
      // Valid pulse and hold; idle cycles carry X on wr_data.
      tbl[5]  = mk(1, 5'd3, 32'h0000BEEF, 0, 5'd0, 0, 5'd0, 0, 0, 16'd34);
      tbl[6]  = mk(0, 5'd0, 32'h0,        1, 5'd3, 1, 5'd3, 32'h0000BEEF, 32'h0000BEEF, 16'd34);
      tbl[7]  = mk(0, 5'd3, 32'hx,        0, 5'd0, 0, 5'd0, 0, 0, 16'd34);
      tbl[8]  = mk(0, 5'd3, 32'hx,        0, 5'd0, 0, 5'd0, 0, 0, 16'd34);
      tbl[9]  = mk(0, 5'd3, 32'hx,        0, 5'd0, 0, 5'd0, 0, 0, 16'd34);
      tbl[10] = mk(0, 5'd0, 32'h0,        1, 5'd3, 0, 5'd0, 32'h0000BEEF, 0, 16'd34);

      hold_a = '0;
      hold_b = '0;
      idle_inputs();
      rst = 1'b1;
      #3;
      chk("reset valid_a", {31'd0, rd_valid_a}, 32'd0);
      chk("reset valid_b", {31'd0, rd_valid_b}, 32'd0);
      chk("reset data_a", rd_data_a, 32'd0);
      chk("reset data_b", rd_data_b, 32'd0);
      chk("reset wr_count", {16'd0, wr_count}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Reset mid-operation with a read in flight.
      drive(mk(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 0, 5'd0, 0, 0, 16'd1), "rst wr r5");
      drive(mk(0, 5'd0, 32'h0, 1, 5'd5, 0, 5'd0, 32'hDEADBEEF, 0, 16'd1), "rst rd r5");
      #2;
      idle_inputs();
      rst = 1'b1;
      #1;
      chk("async rst valid_a", {31'd0, rd_valid_a}, 32'd0);
      chk("async rst data_a", rd_data_a, 32'd0);
      chk("async rst wr_count", {16'd0, wr_count}, 32'd0);
      hold_a = '0;
      @(negedge clk);
      rst = 1'b0;
      drive(mk(0, 5'd0, 32'h0, 1, 5'd5, 0, 5'd0, 32'h0, 0, 16'd0), "post rst rd r5");

      for (int i = 0; i < 2; i++) drive(tbl[i], $sformatf("vec%0d", i));

      // Full sweep: fill r1..r31, then A ascending / B descending.
      for (int i = 1; i < 32; i++)
         drive(mk(1, 5'(i), 32'hA5A50000 + 32'(i), 0, 5'd0, 0, 5'd0, 0, 0, 16'(i)),
               $sformatf("sweep wr r%0d", i));
      for (int j = 0; j < 32; j++) begin
         ea = (j == 0) ? 32'h0 : 32'hA5A50000 + 32'(j);
         eb = (j == 31) ? 32'h0 : 32'hA5A50000 + 32'(31 - j);
         drive(mk(0, 5'd0, 32'h0, 1, 5'(j), 1, 5'(31 - j), ea, eb, 16'd31),
               $sformatf("sweep rd %0d", j));
      end

      for (int i = 2; i < 11; i++) drive(tbl[i], $sformatf("vec%0d", i));

      // Counter saturation: 65540 writes to r1 starting from count 34.
      ec = 16'd34;
      for (int k = 1; k <= 65540; k++) begin
         if (ec != 16'hFFFF) ec = ec + 16'd1;
         drive(mk(1, 5'd1, 32'(k), 0, 5'd0, 0, 5'd0, 0, 0, ec), "sat wr r1");
      end
      drive(mk(0, 5'd0, 32'h0, 1, 5'd1, 1, 5'd1, 32'd65540, 32'd65540, 16'hFFFF), "sat rd r1");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
